// File: rtl/add_sub_pkg.sv
// ---------------------------------------------------------------------------
// add_sub_pkg
//
// Purpose : shared definitions for the digit-serial add/subtract unit.
//           - state_t     : controller states (IDLE, RUN, DONE)
//           - OP_ADD/OP_SUB : values of the mode input s
//           - num_digits  : number of digit cycles for a WIDTH/DIGIT pair
// Ports   : none (package).
// ---------------------------------------------------------------------------
package add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Number of digit cycles needed to walk a WIDTH-bit operand DIGIT bits
  // at a time. Callers guarantee width is a multiple of digit.
  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

endpackage : add_sub_pkg

// File: rtl/add_sub_digit.sv
// ---------------------------------------------------------------------------
// add_sub_digit
//
// Purpose : DIGIT-bit combinational ripple-carry adder slice. It is the only
//           arithmetic element of serial_add_sub and is reused every digit
//           cycle. Besides the carry out it exports the carry into its MSB so
//           the parent can form signed overflow on the final digit.
// Ports   :
//   a   in  [DIGIT-1:0]  addend digit
//   b   in  [DIGIT-1:0]  addend digit (already inverted for subtract)
//   ci  in  1            carry in
//   sum out [DIGIT-1:0]  sum digit
//   co  out 1            carry out of the MSB
//   cm  out 1            carry into the MSB
// ---------------------------------------------------------------------------
module add_sub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] sum,
  output logic             co,
  output logic             cm
);

  // c[i] is the carry into bit i; c[DIGIT] is the carry out of the slice.
  logic [DIGIT:0] c;

  assign c[0] = ci;

  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
      logic p;
      assign p          = a[gi] ^ b[gi];
      assign sum[gi]    = p ^ c[gi];
      assign c[gi + 1]  = (a[gi] & b[gi]) | (p & c[gi]);
    end
  endgenerate

  assign co = c[DIGIT];
  assign cm = c[DIGIT - 1];

endmodule : add_sub_digit

// File: rtl/serial_add_sub.sv
// ---------------------------------------------------------------------------
// serial_add_sub
//
// Purpose : digit-serial two's-complement adder/subtractor. Operands are
//           captured on an accepted start, then DIGIT bits per clock are fed
//           LSB-digit first through a single add_sub_digit slice. Subtract is
//           a + ~b + 1, the +1 coming from presetting the carry to s.
//           A one-cycle done pulse accompanies updated o/co/ov.
//
// Optional feature (compile-time macro SERIAL_ADD_SUB_OVF_EN):
//   defined   : ov = carry into MSB ^ carry out of MSB on the last digit,
//               registered on entry to DONE.
//   undefined : no overflow logic; ov is tied to 0.
//
// Parameters:
//   WIDTH  operand/result width, must be a multiple of DIGIT
//   DIGIT  bits processed per clock
//
// Ports:
//   clk    in  1       clock, rising edge
//   rst    in  1       asynchronous active-high reset
//   start  in  1       request, sampled in IDLE or DONE
//   s      in  1       0 = a + b, 1 = a - b
//   a      in  WIDTH   first operand
//   b      in  WIDTH   second operand
//   busy   out 1       high while digits are being processed
//   done   out 1       one-cycle completion pulse
//   o      out WIDTH   result, held until the next completion
//   co     out 1       final carry (subtract: 1 = no borrow)
//   ov     out 1       signed overflow (0 when the feature is not built)
// ---------------------------------------------------------------------------
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] o,
  output logic             co,
  output logic             ov
);

  import add_sub_pkg::*;

  localparam int N  = num_digits(WIDTH, DIGIT);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_param_check
      $error("serial_add_sub: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Controller
  // -------------------------------------------------------------------------
  state_t state_reg, state_next;
  logic   accept;     // start taken this cycle (IDLE or DONE)
  logic   last_digit; // RUN cycle working on digit N-1

  logic [CW-1:0] cnt_reg;

  assign last_digit = (state_reg == RUN) && (cnt_reg == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt_reg == LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        // A start seen here begins the next operation with no idle gap.
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] a_sh_reg;   // shifts right one digit per RUN cycle
  logic [WIDTH-1:0] b_sh_reg;
  logic             mode_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] acc_reg;    // result digits enter at the top
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] o_reg;
  logic             co_reg;

  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic [DIGIT-1:0] dig_sum;
  logic             dig_co;
  logic             dig_cm;

  assign dig_a = a_sh_reg[DIGIT-1:0];
  assign dig_b = (mode_reg == OP_SUB) ? ~b_sh_reg[DIGIT-1:0] : b_sh_reg[DIGIT-1:0];

  add_sub_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a   (dig_a),
    .b   (dig_b),
    .ci  (carry_reg),
    .sum (dig_sum),
    .co  (dig_co),
    .cm  (dig_cm)
  );

  // Shift the new sum digit in from the MSB end; after N digits the first
  // digit has reached bit 0. Written as shift/or so it also holds for N == 1.
  assign acc_next = (acc_reg >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      mode_reg  <= OP_ADD;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      o_reg     <= '0;
      co_reg    <= 1'b0;
    end else begin
      if (accept) begin
        a_sh_reg  <= a;
        b_sh_reg  <= b;
        mode_reg  <= s;
        carry_reg <= s;   // +1 of the two's-complement negation of b
        cnt_reg   <= '0;
      end else if (state_reg == RUN) begin
        a_sh_reg  <= a_sh_reg >> DIGIT;
        b_sh_reg  <= b_sh_reg >> DIGIT;
        carry_reg <= dig_co;
        cnt_reg   <= cnt_reg + CW'(1);
        acc_reg   <= acc_next;
      end
      if (last_digit) begin
        o_reg  <= acc_next;
        co_reg <= dig_co;
      end
    end
  end

  assign o  = o_reg;
  assign co = co_reg;

`ifdef SERIAL_ADD_SUB_OVF_EN
  logic ov_reg;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_reg <= 1'b0;
    end else if (last_digit) begin
      ov_reg <= dig_cm ^ dig_co;
    end
  end

  assign ov = ov_reg;
`else
  logic cm_unused;

  assign cm_unused = dig_cm;
  assign ov        = 1'b0;
`endif

endmodule : serial_add_sub

// File: doc/serial_add_sub.md
# serial_add_sub

Parametrised, digit-serial two's-complement adder/subtractor: the multi-cycle successor to the 2-bit combinational add/subtract ALU. It accepts two WIDTH-bit operands and a mode bit with a start pulse, then processes DIGIT bits per clock through one shared adder slice. It signals completion with a one-cycle done pulse. It sits beside the existing ALU datapath wherever a wide add/subtract is needed and area matters more than latency.

## Interface
- WIDTH, 8: operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 1: bits processed per clock. N = WIDTH/DIGIT is the number of digit cycles.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only in IDLE or DONE.
- s  in  1  mode: 0 = add (a + b), 1 = subtract (a - b).
- a  in  WIDTH  first operand; captured when start is accepted.
- b  in  WIDTH  second operand; captured when start is accepted.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse; result outputs valid and updated.
- o  out  WIDTH  result, held until the next completion.
- co  out  1  final carry out. In subtract mode, 1 means no borrow (a >= b unsigned).
- ov  out  1  signed overflow; see Configuration.

## Operation
- FSM states:
  - IDLE: start=1 captures a, b and s, clears the digit counter, presets carry = s, and moves to RUN.
  - RUN: each cycle adds digit k of a to digit k of (s ? ~b : b) plus the carry. The DIGIT-bit sum is shifted into an internal result register and the carry is updated. When k = N-1, the FSM moves to DONE and loads o, co and ov from the final values.
  - DONE: done=1 for exactly one cycle. start=1 here is accepted exactly as in IDLE (back-to-back operation); otherwise the FSM returns to IDLE.
- start in RUN is ignored; it is not queued. Operand changes during RUN have no effect.
- Subtraction is a + ~b + 1, with the +1 supplied by the initial carry. No separate subtractor path exists.
- o, co and ov change only on the edge entering DONE. Outside that edge they hold.
- Arithmetic is modulo 2^WIDTH, and bits are processed LSB-digit first.
- rst at any time, including mid-RUN:
  - state goes to IDLE and the operation is aborted;
  - busy, done, o, co and ov all go to 0;
  - no done pulse is issued for the aborted operation.

## Timing
- Reset values: busy=0, done=0, o=0, co=0, ov=0, state IDLE.
- Latency: start accepted at edge E means busy=1 from E through E+N, and done=1 in the cycle following edge E+N.
- Throughput: one operation per N+1 cycles when start is held high or re-asserted in DONE.
- DIGIT=WIDTH gives N=1: a result every 2 cycles.
- No combinational path from inputs to outputs; all outputs are registered.

## Configuration
- SERIAL_ADD_SUB_OVF_EN:
  - Defined: ov is computed as the carry into the MSB XOR the carry out of the MSB during the last digit cycle, and is registered on entry to DONE.
  - Undefined: the overflow logic is not built and ov is tied to 0. The port list is identical in both cases.

## Structure
- Shared package add_sub_pkg holds:
  - the state typedef (IDLE, RUN, DONE);
  - mode constants OP_ADD=1'b0 and OP_SUB=1'b1;
  - a helper function computing N from WIDTH and DIGIT.
- One sub-module, add_sub_digit: a DIGIT-bit combinational ripple adder with ci/co that also exports the carry into its MSB for the ov computation. It is instantiated once.
- The top level holds the FSM, the digit counter, the operand shift registers and the result registers.
- An elaboration-time check rejects WIDTH % DIGIT != 0.

## Test plan
- WIDTH=8, DIGIT=1: a=0x35, b=0x4A, s=0, start at edge E → done in cycle after E+8, o=0x7F, co=0, ov=0.
- WIDTH=8, DIGIT=2: a=0x10, b=0x20, s=1 → o=0xF0, co=0 (borrow); ov=0 with SERIAL_ADD_SUB_OVF_EN defined.
- WIDTH=8, DIGIT=4: a=0x7F, b=0x01, s=0 → o=0x80, co=0, ov=1 with macro defined, ov=0 without it.
- Back-to-back, WIDTH=4, DIGIT=1:
  - first operation a=0x9, b=0x9, add → o=0x2, co=1;
  - start held high → second operation a=0x3, b=0x1, sub, captured at the done edge → o=0x2, co=1, exactly 5 cycles later.
- Abort: start an 8-bit add, assert rst at RUN digit 3 → all outputs 0 immediately; no done pulse. A new start after rst release completes normally.
- Ignored start: start pulsed during RUN with different operands → result reflects only the first operation; no extra done pulse.
